modulo_unit_param: RTL

// Self-contained, parametrised modulo/division unit: own FSM plus restoring shift-subtract datapath.

---
 rtl/modulo_unit_if.sv | 31 +++
 rtl/modulo_unit_param.sv | 127 ++++++++++++
 2 files changed

// File: rtl/modulo_unit_if.sv
// Start/valid request bundle for the modulo/division unit.
// Operands go in with start_i, results come back with valid_o.
interface modulo_unit_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] zahl1_i;
  logic [WIDTH-1:0] zahl2_i;
  logic             busy_o;
  logic             valid_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] ergebnis_o;

  modport master (
    output start_i, signed_i,
    output zahl1_i, zahl2_i,
    input  busy_o, valid_o,
    input  div_zero_o,
    input  quotient_o, ergebnis_o
  );

  modport slave (
    input  start_i, signed_i,
    input  zahl1_i, zahl2_i,
    output busy_o, valid_o,
    output div_zero_o,
    output quotient_o, ergebnis_o
  );
endinterface

// File: rtl/modulo_unit_param.sv
// Sequential restoring divider: one quotient bit per cycle,
// optional two's-complement operands with sign fix-up at the end.
module modulo_unit_param #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_ni,
  modulo_unit_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  logic             busy_q;
  logic             valid_q;
  logic             dz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] erg_q;

  logic             accept;
  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign accept = bus.start_i &&
                  (state == IDLE || state == DONE);
  assign sgn    = SIGNED_EN & bus.signed_i;

  always_comb begin
    a_mag = bus.zahl1_i;
    b_mag = bus.zahl2_i;
    if (sgn && bus.zahl1_i[WIDTH-1])
      a_mag = WIDTH'(0) - bus.zahl1_i;
    if (sgn && bus.zahl2_i[WIDTH-1])
      b_mag = WIDTH'(0) - bus.zahl2_i;
  end

  // rem < dsr always, so a successful subtract fits in WIDTH bits
  assign trial = {rem, dvd[WIDTH-1]};
  assign ge    = trial >= {1'b0, dsr};
  assign diff  = trial[WIDTH-1:0] - dsr;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      erg_q   <= '0;
    end else if (accept) begin
      dvd   <= a_mag;
      dsr   <= b_mag;
      rem   <= '0;
      cnt   <= CW'(WIDTH-1);
      neg_q <= sgn &
               (bus.zahl1_i[WIDTH-1] ^ bus.zahl2_i[WIDTH-1]);
      neg_r <= sgn & bus.zahl1_i[WIDTH-1];
      if (bus.zahl2_i == '0) begin
        state   <= DONE;
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
        dz_q    <= 1'b1;
        quo_q   <= '1;
        erg_q   <= bus.zahl1_i;
      end else begin
        state   <= CALC;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: valid_q <= 1'b0;
        CALC: begin
          rem <= ge ? diff : trial[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ge};
          if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - 1'b1;
        end
        FIX: begin
          quo_q   <= neg_q ? WIDTH'(0) - dvd : dvd;
          erg_q   <= neg_r ? WIDTH'(0) - rem : rem;
          dz_q    <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.valid_o    = valid_q;
  assign bus.div_zero_o = dz_q;
  assign bus.quotient_o = quo_q;
  assign bus.ergebnis_o = erg_q;
endmodule
